// File: rtl/bank_isu_pkg.sv
// Shared definitions for the bank issue unit: opcodes, fixed field widths
// and the packed control part of a buffered request.
package bank_isu_pkg;

    localparam logic [2:0] OPC_READ     = 3'd0;
    localparam logic [2:0] OPC_WRITE    = 3'd1;
    localparam logic [2:0] OPC_LINEFILL = 3'd2;
    localparam logic [2:0] OPC_EVICT    = 3'd3;

    localparam int OPC_W   = 3;
    localparam int WBID_W  = 8;
    localparam int ROB_W   = 3;
    localparam int DIRTY_W = 2;
    localparam int CHID_W  = 2;

    // Fixed-width request fields; set/way/offset and linefill data are
    // parameter-sized and travel next to this struct in the FIFO word.
    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [WBID_W-1:0]  wbuffer_id;
        logic [ROB_W-1:0]   xbar_rob_num;
        logic [DIRTY_W-1:0] dirty_offset1;
        logic [DIRTY_W-1:0] dirty_offset0;
    } isu_req_t;

endpackage

// File: rtl/bank_isu_fifo.sv
// Synchronous per-channel request FIFO with asynchronous reset of the
// pointers and occupancy; storage itself is never reset.
module bank_isu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bank_isu_arb.sv
// Multi-channel issue unit in front of the bank storage controller.
// Per-channel FIFOs feed a round-robin arbiter and a registered
// valid/ready output stage. Define ISU_PERF_CNT_EN to add the saturating
// issue/stall performance counters and their output ports.
module bank_isu_arb
    import bank_isu_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SWO_W      = 7,
    parameter int DATA_W     = 128
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [CH_NUM-1:0]          ch_valid_i,
    output logic [CH_NUM-1:0]          ch_ready_o,
    input  logic [CH_NUM*3-1:0]        ch_opcode_i,
    input  logic [CH_NUM*SWO_W-1:0]    ch_set_way_offset_i,
    input  logic [CH_NUM*8-1:0]        ch_wbuffer_id_i,
    input  logic [CH_NUM*3-1:0]        ch_xbar_rob_num_i,
    input  logic [CH_NUM*4-1:0]        ch_dirty_i,
    input  logic [CH_NUM*2*DATA_W-1:0] ch_data_i,
    output logic                       isu_sc_valid_o,
    input  logic                       isu_sc_ready_i,
    output logic [1:0]                 isu_sc_channel_id_o,
    output logic [2:0]                 isu_sc_opcode_o,
    output logic [SWO_W-1:0]           isu_sc_set_way_offset_o,
    output logic [7:0]                 isu_sc_wbuffer_id_o,
    output logic [2:0]                 isu_sc_xbar_rob_num_o,
    output logic [1:0]                 isu_sc_cacheline_dirty_offset0_o,
    output logic [1:0]                 isu_sc_cacheline_dirty_offset1_o,
    output logic [DATA_W-1:0]          isu_sc_linefill_data_offset0_o,
    output logic [DATA_W-1:0]          isu_sc_linefill_data_offset1_o,
    output logic                       isu_busy_o
`ifdef ISU_PERF_CNT_EN
    ,
    output logic [31:0]                isu_perf_issue_cnt_o,
    output logic [31:0]                isu_perf_stall_cnt_o
`endif
);

    localparam int CTRL_W = $bits(isu_req_t);
    localparam int REQ_W  = CTRL_W + SWO_W + 2*DATA_W;
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    logic [REQ_W-1:0]  wdata [CH_NUM];
    logic [REQ_W-1:0]  rdata [CH_NUM];
    logic [CH_NUM-1:0] push;
    logic [CH_NUM-1:0] pop;
    logic [CH_NUM-1:0] full;
    logic [CH_NUM-1:0] empty;

    logic              state;
    logic [CHID_W-1:0] rr_ptr;
    logic [CHID_W-1:0] grant;
    logic [CHID_W-1:0] next_ptr;
    logic              any_req;
    logic              load;
    logic              take;
    logic [REQ_W-1:0]  sel;

    isu_req_t          ctrl_p1;
    logic [CHID_W-1:0] chid_p1;
    logic [SWO_W-1:0]  swo_p1;
    logic [DATA_W-1:0] data0_p1;
    logic [DATA_W-1:0] data1_p1;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        isu_req_t ctrl;
        assign ctrl.opcode        = ch_opcode_i[3*c +: OPC_W];
        assign ctrl.wbuffer_id    = ch_wbuffer_id_i[8*c +: WBID_W];
        assign ctrl.xbar_rob_num  = ch_xbar_rob_num_i[3*c +: ROB_W];
        assign ctrl.dirty_offset0 = ch_dirty_i[4*c +: DIRTY_W];
        assign ctrl.dirty_offset1 = ch_dirty_i[4*c+2 +: DIRTY_W];
        assign wdata[c] = {ctrl, ch_set_way_offset_i[SWO_W*c +: SWO_W],
                           ch_data_i[2*DATA_W*c +: 2*DATA_W]};
        assign push[c]  = ch_valid_i[c];
        assign pop[c]   = take && (grant == CHID_W'(c));

        bank_isu_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (REQ_W)
        ) u_fifo (
            .clk   (clk_i),
            .rst   (rst_i),
            .push  (push[c]),
            .pop   (pop[c]),
            .wdata (wdata[c]),
            .full  (full[c]),
            .empty (empty[c]),
            .rdata (rdata[c])
        );
    end

    assign ch_ready_o = ~full;

    // Round-robin pick: first non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        logic [CHID_W:0] sum;
        grant   = '0;
        any_req = 1'b0;
        sum     = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            sum = {1'b0, rr_ptr} + (CHID_W+1)'(i);
            if (sum >= (CHID_W+1)'(CH_NUM)) sum = sum - (CHID_W+1)'(CH_NUM);
            if (!any_req && !empty[sum[CHID_W-1:0]]) begin
                any_req = 1'b1;
                grant   = sum[CHID_W-1:0];
            end
        end
    end

    assign next_ptr = (grant == CHID_W'(CH_NUM-1)) ? '0 : grant + 1'b1;
    assign load     = (state == ST_EMPTY) || (isu_sc_valid_o && isu_sc_ready_i);
    assign take     = load && any_req;
    assign sel      = rdata[grant];

    // ---- stage p1: registered request toward sc ----
    // Output FSM and payload register; payload is frozen while HOLD stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_EMPTY;
            rr_ptr   <= '0;
            chid_p1  <= '0;
            ctrl_p1  <= '0;
            swo_p1   <= '0;
            data0_p1 <= '0;
            data1_p1 <= '0;
        end else if (load) begin
            if (any_req) begin
                state    <= ST_HOLD;
                rr_ptr   <= next_ptr;
                chid_p1  <= grant;
                ctrl_p1  <= sel[REQ_W-1 -: CTRL_W];
                swo_p1   <= sel[2*DATA_W +: SWO_W];
                data1_p1 <= sel[DATA_W +: DATA_W];
                data0_p1 <= sel[0 +: DATA_W];
            end else begin
                state <= ST_EMPTY;
            end
        end
    end

    assign isu_sc_valid_o                   = (state == ST_HOLD);
    assign isu_sc_channel_id_o              = chid_p1;
    assign isu_sc_opcode_o                  = ctrl_p1.opcode;
    assign isu_sc_set_way_offset_o          = swo_p1;
    assign isu_sc_wbuffer_id_o              = ctrl_p1.wbuffer_id;
    assign isu_sc_xbar_rob_num_o            = ctrl_p1.xbar_rob_num;
    assign isu_sc_cacheline_dirty_offset0_o = ctrl_p1.dirty_offset0;
    assign isu_sc_cacheline_dirty_offset1_o = ctrl_p1.dirty_offset1;
    assign isu_sc_linefill_data_offset0_o   = data0_p1;
    assign isu_sc_linefill_data_offset1_o   = data1_p1;
    assign isu_busy_o                       = (|(~empty)) | isu_sc_valid_o;

`ifdef ISU_PERF_CNT_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;

    // Saturating handshake and stall-cycle counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (isu_sc_valid_o && isu_sc_ready_i && issue_cnt != 32'hFFFF_FFFF)
                issue_cnt <= issue_cnt + 32'd1;
            if (isu_sc_valid_o && !isu_sc_ready_i && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign isu_perf_issue_cnt_o = issue_cnt;
    assign isu_perf_stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_bank_isu_arb.sv
// Directed testbench for bank_isu_arb: reset, latency, round-robin order,
// backpressure, FIFO pointer wrap and mid-flight asynchronous reset.
module tb_bank_isu_arb;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    ch_valid = '0;
    logic [3:0]    ch_ready;
    logic [11:0]   ch_opcode = '0;
    logic [27:0]   ch_swo = '0;
    logic [31:0]   ch_wbid = '0;
    logic [11:0]   ch_rob = '0;
    logic [15:0]   ch_dirty = '0;
    logic [1023:0] ch_data = '0;
    logic          valid;
    logic          ready = 1'b1;
    logic [1:0]    chid;
    logic [2:0]    opcode;
    logic [6:0]    swo;
    logic [7:0]    wbid;
    logic [2:0]    rob;
    logic [1:0]    dirty0;
    logic [1:0]    dirty1;
    logic [127:0]  data0;
    logic [127:0]  data1;
    logic          busy;
`ifdef ISU_PERF_CNT_EN
    logic [31:0]   issue_cnt;
    logic [31:0]   stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bank_isu_arb dut (
        .clk_i                            (clk),
        .rst_i                            (rst),
        .ch_valid_i                       (ch_valid),
        .ch_ready_o                       (ch_ready),
        .ch_opcode_i                      (ch_opcode),
        .ch_set_way_offset_i              (ch_swo),
        .ch_wbuffer_id_i                  (ch_wbid),
        .ch_xbar_rob_num_i                (ch_rob),
        .ch_dirty_i                       (ch_dirty),
        .ch_data_i                        (ch_data),
        .isu_sc_valid_o                   (valid),
        .isu_sc_ready_i                   (ready),
        .isu_sc_channel_id_o              (chid),
        .isu_sc_opcode_o                  (opcode),
        .isu_sc_set_way_offset_o          (swo),
        .isu_sc_wbuffer_id_o              (wbid),
        .isu_sc_xbar_rob_num_o            (rob),
        .isu_sc_cacheline_dirty_offset0_o (dirty0),
        .isu_sc_cacheline_dirty_offset1_o (dirty1),
        .isu_sc_linefill_data_offset0_o   (data0),
        .isu_sc_linefill_data_offset1_o   (data1),
        .isu_busy_o                       (busy)
`ifdef ISU_PERF_CNT_EN
        ,
        .isu_perf_issue_cnt_o             (issue_cnt),
        .isu_perf_stall_cnt_o             (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request on channel c; side fields are derived from swo_v.
    task automatic set_ch(input int c, input logic [6:0] swo_v, input logic [127:0] dat);
        ch_valid[c]         = 1'b1;
        ch_opcode[3*c +: 3] = swo_v[2:0];
        ch_swo[7*c +: 7]    = swo_v;
        ch_wbid[8*c +: 8]   = {1'b0, swo_v} + 8'h30;
        ch_rob[3*c +: 3]    = swo_v[4:2];
        ch_dirty[4*c +: 4]  = swo_v[3:0];
        ch_data[256*c +: 256] = {dat + 128'd1, dat};
    endtask

    task automatic expect_out(input string tag, input int c, input logic [6:0] swo_v,
                              input logic [127:0] dat);
        logic [7:0] wb;
        wb = {1'b0, swo_v} + 8'h30;
        chk({tag, " valid"}, 256'(valid), 256'(1));
        chk({tag, " chid"}, 256'(chid), 256'(c));
        chk({tag, " swo"}, 256'(swo), 256'(swo_v));
        chk({tag, " fields"}, 256'({opcode, wbid, rob, dirty1, dirty0}),
            256'({swo_v[2:0], wb, swo_v[4:2], swo_v[3:2], swo_v[1:0]}));
        chk({tag, " data0"}, 256'(data0), 256'(dat));
        chk({tag, " data1"}, 256'(data1), 256'(dat + 128'd1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ch_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst valid", 256'(valid), 256'(0));
        chk("rst ready", 256'(ch_ready), 256'(4'hF));
        chk("rst busy", 256'(busy), 256'(0));
        chk("rst swo", 256'(swo), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single request on ch2: visible two cycles after the push
        ready = 1'b1;
        @(negedge clk);
        set_ch(2, 7'd5, 128'd55);
        @(negedge clk);
        ch_valid = '0;
        chk("lat valid n+1", 256'(valid), 256'(0));
        chk("lat busy n+1", 256'(busy), 256'(1));
        @(negedge clk);
        expect_out("lat", 2, 7'd5, 128'd55);
        @(negedge clk);
        chk("lat valid after", 256'(valid), 256'(0));
        chk("lat busy after", 256'(busy), 256'(0));

        // Round robin: two requests on every channel, ready held high
        do_reset();
        ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 4; c++) set_ch(c, 7'(c), 128'(c));
        @(negedge clk);
        ch_valid = '0;
        for (int c = 0; c < 4; c++) set_ch(c, 7'(10 + c), 128'(10 + c));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) ch_valid = '0;
            expect_out("rr", i % 4, (i < 4) ? 7'(i) : 7'(6 + i), (i < 4) ? 128'(i) : 128'(6 + i));
        end
        @(negedge clk);
        chk("rr drained", 256'(valid), 256'(0));

        // Backpressure on ch0
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ch_valid = '0;
            chk("bp ch0 ready", 256'(ch_ready[0]), 256'(1));
            set_ch(0, 7'(20 + i), 128'(200 + i));
        end
        @(negedge clk);
        ch_valid = '0;
        chk("bp ch0 full", 256'(ch_ready[0]), 256'(0));
        set_ch(0, 7'd99, 128'd999);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ch_valid = '0;
            chk("bp hold valid", 256'(valid), 256'(1));
            chk("bp hold swo", 256'(swo), 256'(20));
            chk("bp hold data", 256'(data0), 256'(200));
            chk("bp hold full", 256'(ch_ready[0]), 256'(0));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ready = 1'b1;
            expect_out("bp drain", 0, 7'(20 + i), 128'(200 + i));
        end
        @(negedge clk);
        chk("bp drained", 256'(valid), 256'(0));

        // Pointer wrap: nine requests streamed through ch1
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ch_valid = '0;
            if (k >= 2 && k < 11) expect_out("wrap", 1, 7'(2 * (k - 2)), 128'(100 * (k - 2)));
            if (k == 11) chk("wrap end valid", 256'(valid), 256'(0));
            if (k < 9) begin
                chk("wrap ch1 ready", 256'(ch_ready[1]), 256'(1));
                set_ch(1, 7'(2 * k), 128'(100 * k));
            end
        end

        // Asynchronous reset while a request is held and three are buffered
        do_reset();
        ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) set_ch(c, 7'(40 + c), 128'(c + 1));
        @(negedge clk);
        ch_valid = '0;
        @(negedge clk);
        expect_out("mid pre", 0, 7'd40, 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid rst valid", 256'(valid), 256'(0));
        chk("mid rst swo", 256'(swo), 256'(0));
        chk("mid rst data", 256'(data0), 256'(0));
        chk("mid rst busy", 256'(busy), 256'(0));
        chk("mid rst ready", 256'(ch_ready), 256'(4'hF));
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid post valid", 256'(valid), 256'(0));
            chk("mid post busy", 256'(busy), 256'(0));
        end

`ifdef ISU_PERF_CNT_EN
        // Five requests: seven stall cycles, then five handshakes
        do_reset();
        ready = 1'b0;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            ch_valid = '0;
            if (t < 4) set_ch(0, 7'(t), 128'(t));
            if (t == 0) set_ch(1, 7'd9, 128'd9);
            if (t == 9) ready = 1'b1;
        end
        chk("perf issue", 256'(issue_cnt), 256'(5));
        chk("perf stall", 256'(stall_cnt), 256'(7));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
